// File: rtl/vectored_int_ctrl.sv
// Vectored interrupt controller: per-channel edge/level capture, two-class fixed-priority
// arbitration, and a REQ/ACK/EOI handshake toward the processor.
//
// state   | meaning
// IDLE    | no request outstanding; arbitrate eligible channels each cycle
// REQ     | EIC_IntReq asserted with a frozen EIC_IntId, waiting for EIC_IntAck
// SERVICE | handler running (InService=1); waiting for an EOI write
module vectored_int_ctrl #(
  parameter int NUM_IRQ = 16,
  parameter int ID_W    = $clog2(NUM_IRQ)
) (
  input  logic               Sys_Clock,
  input  logic               Sys_Reset,
  input  logic [NUM_IRQ-1:0] IrqIn,
  input  logic               Sys_BlockSelect,
  input  logic [3:0]         Sys_RegAddress,
  input  logic               Sys_WrEn,
  input  logic               Sys_RdEn,
  input  logic [31:0]        Sys_WrData,
  output logic [31:0]        Sys_RdData,
  output logic               EIC_IntReq,
  output logic [ID_W-1:0]    EIC_IntId,
  input  logic               EIC_IntAck
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REQ     = 2'b01,
    SERVICE = 2'b10
  } ctrlState;

  localparam logic [3:0] ADDR_ENABLE  = 4'd0;
  localparam logic [3:0] ADDR_MODE    = 4'd1;
  localparam logic [3:0] ADDR_PRIO    = 4'd2;
  localparam logic [3:0] ADDR_PENDING = 4'd3;
  localparam logic [3:0] ADDR_STATUS  = 4'd4;
  localparam logic [3:0] ADDR_EOI     = 4'd5;

  ctrlState           state;
  logic [NUM_IRQ-1:0] enableReg;
  logic [NUM_IRQ-1:0] modeReg;
  logic [NUM_IRQ-1:0] prioReg;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] irqPrev;
  logic               inService;
  logic [ID_W-1:0]    serviceId;

  logic               wrStrobe;
  logic               rdStrobe;
  logic               w1cWrite;
  logic               eoiWrite;
  logic [NUM_IRQ-1:0] wrBits;
  logic [NUM_IRQ-1:0] edgeSet;
  logic [NUM_IRQ-1:0] w1cClr;
  logic [NUM_IRQ-1:0] ackClr;
  logic [NUM_IRQ-1:0] pendingNext;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] highEligible;
  logic [NUM_IRQ-1:0] winnerPool;
  logic [ID_W-1:0]    winnerId;
  logic               anyEligible;
  logic [31:0]        rdValue;
  logic               unusedWrBits;

  assign wrStrobe = Sys_BlockSelect & Sys_WrEn;
  assign rdStrobe = Sys_BlockSelect & Sys_RdEn;
  assign w1cWrite = wrStrobe && (Sys_RegAddress == ADDR_PENDING);
  assign eoiWrite = wrStrobe && (Sys_RegAddress == ADDR_EOI);
  assign wrBits   = Sys_WrData[NUM_IRQ-1:0];

  // Write-data bits above the channel count are intentionally dropped.
  assign unusedWrBits = ^Sys_WrData;

  assign edgeSet = IrqIn & ~irqPrev;
  assign w1cClr  = w1cWrite ? wrBits : '0;

  always_comb begin
    ackClr = '0;
    if (state == REQ && EIC_IntAck) begin
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (EIC_IntId == ID_W'(i)) ackClr[i] = 1'b1;
      end
    end
  end

  // Edge channels: a new edge beats any same-cycle clear. Level channels track the pin.
  assign pendingNext = (modeReg & (edgeSet | (pending & ~(w1cClr | ackClr))))
                     | (~modeReg & IrqIn);

  assign eligible     = pending & enableReg;
  assign highEligible = eligible & prioReg;
  assign anyEligible  = |eligible;
  assign winnerPool   = (|highEligible) ? highEligible : eligible;

  always_comb begin
    winnerId = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (winnerPool[i]) winnerId = ID_W'(i);
    end
  end

  always_comb begin
    rdValue = '0;
    case (Sys_RegAddress)
      ADDR_ENABLE:  rdValue[NUM_IRQ-1:0] = enableReg;
      ADDR_MODE:    rdValue[NUM_IRQ-1:0] = modeReg;
      ADDR_PRIO:    rdValue[NUM_IRQ-1:0] = prioReg;
      ADDR_PENDING: rdValue[NUM_IRQ-1:0] = pending;
      ADDR_STATUS: begin
        rdValue[31]        = inService;
        rdValue[9:8]       = state;
        rdValue[ID_W-1:0]  = serviceId;
      end
      default: rdValue = '0;
    endcase
  end

  always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
    if (!Sys_Reset) begin
      enableReg  <= '0;
      modeReg    <= '0;
      prioReg    <= '0;
      pending    <= '0;
      irqPrev    <= '0;
      Sys_RdData <= '0;
    end else begin
      irqPrev <= IrqIn;
      pending <= pendingNext;
      if (wrStrobe) begin
        case (Sys_RegAddress)
          ADDR_ENABLE: enableReg <= wrBits;
          ADDR_MODE:   modeReg   <= wrBits;
          ADDR_PRIO:   prioReg   <= wrBits;
          default:     ;
        endcase
      end
      if (rdStrobe) Sys_RdData <= rdValue;
    end
  end

  always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
    if (!Sys_Reset) begin
      state      <= IDLE;
      EIC_IntReq <= 1'b0;
      EIC_IntId  <= '0;
      inService  <= 1'b0;
      serviceId  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (anyEligible) begin
            EIC_IntId  <= winnerId;
            EIC_IntReq <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          if (EIC_IntAck) begin
            EIC_IntReq <= 1'b0;
            serviceId  <= EIC_IntId;
            inService  <= 1'b1;
            state      <= SERVICE;
          end
        end
        SERVICE: begin
          EIC_IntReq <= 1'b0;
          if (eoiWrite) begin
            inService <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          EIC_IntReq <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vectored_int_ctrl.sv
// Directed bench for vectored_int_ctrl: a 16-channel instance for the main scenarios
// and a 32-channel instance for the full-width ID case.
module tb_vectored_int_ctrl;

  logic        clk = 1'b0;
  logic        rstN;
  logic [15:0] irqA;
  logic [31:0] irqB;
  logic        selA, selB, wrEn, rdEn;
  logic [3:0]  addr;
  logic [31:0] wrData;
  logic [31:0] rdA, rdB, rv;
  logic        reqA, reqB, ackA, ackB;
  logic [3:0]  idA;
  logic [4:0]  idB;
  int          compared = 0;
  int          mismatched = 0;

  always #5 clk = ~clk;

  vectored_int_ctrl #(.NUM_IRQ(16)) dutA (
    .Sys_Clock(clk), .Sys_Reset(rstN), .IrqIn(irqA), .Sys_BlockSelect(selA),
    .Sys_RegAddress(addr), .Sys_WrEn(wrEn), .Sys_RdEn(rdEn), .Sys_WrData(wrData),
    .Sys_RdData(rdA), .EIC_IntReq(reqA), .EIC_IntId(idA), .EIC_IntAck(ackA)
  );

  vectored_int_ctrl #(.NUM_IRQ(32)) dutB (
    .Sys_Clock(clk), .Sys_Reset(rstN), .IrqIn(irqB), .Sys_BlockSelect(selB),
    .Sys_RegAddress(addr), .Sys_WrEn(wrEn), .Sys_RdEn(rdEn), .Sys_WrData(wrData),
    .Sys_RdData(rdB), .EIC_IntReq(reqB), .EIC_IntId(idB), .EIC_IntAck(ackB)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic busWrite(input bit toB, input logic [3:0] a, input logic [31:0] d);
    selA = !toB; selB = toB; wrEn = 1'b1; addr = a; wrData = d;
    tick();
    selA = 1'b0; selB = 1'b0; wrEn = 1'b0;
  endtask

  task automatic busRead(input bit fromB, input logic [3:0] a, output logic [31:0] d);
    selA = !fromB; selB = fromB; rdEn = 1'b1; addr = a;
    tick();
    d = fromB ? rdB : rdA;
    selA = 1'b0; selB = 1'b0; rdEn = 1'b0;
  endtask

  task automatic ackPulseA;
    ackA = 1'b1;
    tick();
    ackA = 1'b0;
  endtask

  initial begin
    rstN = 1'b0; irqA = '0; irqB = '0; selA = 1'b0; selB = 1'b0;
    wrEn = 1'b0; rdEn = 1'b0; addr = '0; wrData = '0; ackA = 1'b0; ackB = 1'b0;

    // Reset state
    #3;
    check("rst_req", {31'd0, reqA}, 32'd0);
    check("rst_id", {28'd0, idA}, 32'd0);
    check("rst_rdata", rdA, 32'd0);
    tick(); tick();
    #2 rstN = 1'b1;
    busRead(0, 4'd3, rv); check("rst_pending", rv, 32'd0);
    busRead(0, 4'd4, rv); check("rst_status", rv, 32'd0);

    // Unused upper bits ignore writes
    busWrite(0, 4'd0, 32'hFFFF_FFFF);
    busRead(0, 4'd0, rv); check("enable_mask", rv, 32'h0000_FFFF);
    busWrite(0, 4'd1, 32'h0000_FFFF);
    busRead(0, 4'd1, rv); check("mode_rd", rv, 32'h0000_FFFF);

    // Single edge on channel 5
    irqA = 16'h0020;
    tick();
    irqA = '0;
    check("edge5_k", {31'd0, reqA}, 32'd0);
    tick();
    check("edge5_req", {31'd0, reqA}, 32'd1);
    check("edge5_id", {28'd0, idA}, 32'd5);
    busRead(0, 4'd3, rv); check("edge5_pend_req", rv, 32'h0000_0020);
    ackPulseA();
    check("edge5_ack_req", {31'd0, reqA}, 32'd0);
    busRead(0, 4'd4, rv); check("edge5_status", rv, 32'h8000_0205);
    busRead(0, 4'd3, rv); check("edge5_pend_ack", rv, 32'd0);
    ackPulseA();
    busRead(0, 4'd4, rv); check("ack_in_service", rv, 32'h8000_0205);
    busWrite(0, 4'd5, 32'd0);
    busRead(0, 4'd4, rv); check("eoi_status", rv, 32'h0000_0005);

    // Two edges, channel 9 in the high class
    busWrite(0, 4'd2, 32'h0000_0200);
    irqA = 16'h0208;
    tick();
    irqA = '0;
    tick();
    check("prio_req", {31'd0, reqA}, 32'd1);
    check("prio_id9", {28'd0, idA}, 32'd9);
    ackPulseA();
    busWrite(0, 4'd5, 32'd0);
    check("prio_eoi_req", {31'd0, reqA}, 32'd0);
    tick();
    check("prio_req3", {31'd0, reqA}, 32'd1);
    check("prio_id3", {28'd0, idA}, 32'd3);
    ackPulseA();
    busWrite(0, 4'd5, 32'd0);

    // W1C colliding with a new edge on channel 4: set wins
    irqA = 16'h0010;
    selA = 1'b1; wrEn = 1'b1; addr = 4'd3; wrData = 32'h0000_0010;
    tick();
    selA = 1'b0; wrEn = 1'b0; irqA = '0;
    busRead(0, 4'd3, rv); check("w1c_collide", rv, 32'h0000_0010);
    check("w1c_req", {31'd0, reqA}, 32'd1);
    check("w1c_id4", {28'd0, idA}, 32'd4);
    busWrite(0, 4'd3, 32'h0000_0010);
    busRead(0, 4'd3, rv); check("w1c_clear", rv, 32'd0);
    check("w1c_id_frozen", {28'd0, idA}, 32'd4);
    ackPulseA();
    busWrite(0, 4'd5, 32'd0);
    tick();
    check("w1c_no_req", {31'd0, reqA}, 32'd0);

    // Level channel 2 retracted while in REQ
    busWrite(0, 4'd1, 32'h0000_FFFB);
    irqA = 16'h0004;
    tick(); tick();
    check("lvl_req", {31'd0, reqA}, 32'd1);
    check("lvl_id2", {28'd0, idA}, 32'd2);
    irqA = '0;
    tick(); tick();
    check("lvl_hold_req", {31'd0, reqA}, 32'd1);
    check("lvl_hold_id", {28'd0, idA}, 32'd2);
    ackPulseA();
    check("lvl_ack", {31'd0, reqA}, 32'd0);
    busWrite(0, 4'd5, 32'd0);
    tick(); tick();
    check("lvl_no_rereq", {31'd0, reqA}, 32'd0);

    // Asynchronous reset in the middle of REQ
    busWrite(0, 4'd1, 32'h0000_FFFF);
    irqA = 16'h0080;
    tick();
    irqA = '0;
    tick();
    check("ar_req", {31'd0, reqA}, 32'd1);
    check("ar_id7", {28'd0, idA}, 32'd7);
    #2 rstN = 1'b0;
    #1;
    check("ar_req_drop", {31'd0, reqA}, 32'd0);
    check("ar_id_clr", {28'd0, idA}, 32'd0);
    tick();
    #2 rstN = 1'b1;
    busRead(0, 4'd0, rv); check("ar_enable", rv, 32'd0);
    busRead(0, 4'd1, rv); check("ar_mode", rv, 32'd0);
    busRead(0, 4'd2, rv); check("ar_prio", rv, 32'd0);
    busRead(0, 4'd3, rv); check("ar_pending", rv, 32'd0);
    busRead(0, 4'd4, rv); check("ar_status", rv, 32'd0);

    // 32-channel instance, top channel
    busWrite(1, 4'd0, 32'hFFFF_FFFF);
    busWrite(1, 4'd1, 32'hFFFF_FFFF);
    busRead(1, 4'd0, rv); check("w32_enable", rv, 32'hFFFF_FFFF);
    irqB = 32'h8000_0000;
    tick();
    irqB = '0;
    tick();
    check("w32_req", {31'd0, reqB}, 32'd1);
    check("w32_id31", {27'd0, idB}, 32'd31);
    busRead(1, 4'd7, rv); check("w32_unmapped", rv, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/vectored_int_ctrl.md
VECTORED_INT_CTRL -- requirements
Module: vectored_int_ctrl

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 16, number of interrupt channels (legal range 2..32).
REQ-002 SHALL have parameter ID_W, default $clog2(NUM_IRQ), width of the interrupt ID.
REQ-003 SHALL have port Sys_Clock  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port Sys_Reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port IrqIn  input  NUM_IRQ  interrupt sources, synchronous to Sys_Clock.
REQ-006 SHALL have port Sys_BlockSelect  input  1  register access targets this block.
REQ-007 SHALL have port Sys_RegAddress  input  4  register index.
REQ-008 SHALL have port Sys_WrEn and port Sys_RdEn, each input, 1 bit: write strobe and read strobe.
REQ-009 SHALL have port Sys_WrData  input  32  write data.
REQ-010 SHALL have port Sys_RdData  output  32  registered read data.
REQ-011 SHALL have port EIC_IntReq  output  1  interrupt request to the processor.
REQ-012 SHALL have port EIC_IntId  output  ID_W  channel number of the request.
REQ-013 SHALL have port EIC_IntAck  input  1  single-cycle acknowledge from the processor.

Function
REQ-014 SHALL decode the register map at Sys_RegAddress: 0 ENABLE (RW), 1 MODE (RW; 1 = rising-edge, 0 = level), 2 PRIO (RW; 1 = high class), 3 PENDING (RO; write-1-to-clear edge latches), 4 STATUS (RO), 5 EOI (WO).
REQ-015 SHALL use bits [NUM_IRQ-1:0] of each per-channel register; unused bits SHALL read 0 and ignore writes.
REQ-016 SHALL perform a write only when Sys_BlockSelect=1 and Sys_WrEn=1, taking effect at that clock edge.
REQ-017 SHALL, when Sys_BlockSelect=1 and Sys_RdEn=1, load the addressed register into Sys_RdData at that edge (1-cycle latency); it SHALL otherwise hold its value, and unmapped addresses SHALL read 0.
REQ-018 SHALL make STATUS read as {InService bit 31, State[1:0] bits 9:8, ServiceId in bits ID_W-1:0, all other bits 0}.
REQ-019 SHALL register IrqIn each cycle into IrqPrev; for an edge-mode channel, IrqIn=1 with IrqPrev=0 SHALL set Pending[i] at that edge.
REQ-020 SHALL hold edge-mode Pending[i] until cleared by a PENDING W1C write or by an acknowledge of channel i; if a set and a clear coincide, the set SHALL win.
REQ-021 SHALL make level-mode Pending[i] a register loaded with IrqIn[i] every cycle; W1C SHALL have no effect on it.
REQ-022 SHALL treat a channel as eligible when Pending[i] & Enable[i]; the winner SHALL be the lowest-index eligible high-class channel, else the lowest-index eligible low-class channel.
REQ-023 SHALL implement the state machine IDLE(00) -> REQ(01) -> SERVICE(10) -> IDLE.
REQ-024 IDLE: if any channel is eligible, SHALL register the winner into EIC_IntId, set EIC_IntReq=1 and go to REQ.
REQ-025 REQ: SHALL hold EIC_IntReq=1 and keep EIC_IntId frozen even if the source retracts or is disabled.
REQ-026 REQ with EIC_IntAck=1: SHALL clear EIC_IntReq, copy EIC_IntId to ServiceId, clear Pending[id] if edge-mode, set InService and go to SERVICE.
REQ-027 SERVICE: SHALL not assert EIC_IntReq; a write to EOI SHALL clear InService and go to IDLE, and arbitration SHALL resume the next cycle.
REQ-028 SHALL ignore EIC_IntAck in IDLE and SERVICE, and EOI writes in IDLE and REQ.
REQ-029 Latency: an edge at clock k sets Pending after edge k, and EIC_IntReq=1 SHALL be visible after edge k+1.

Reset
REQ-030 While Sys_Reset=0 the block SHALL immediately clear all registers: ENABLE, MODE, PRIO, Pending, IrqPrev, InService and ServiceId to 0, state to IDLE, and EIC_IntReq, EIC_IntId and Sys_RdData to 0.
REQ-031 A reset in any state, including REQ with EIC_IntReq=1, SHALL drop EIC_IntReq asynchronously; a source held high through reset release SHALL count as an edge.

Verification
REQ-032 Scenario: ENABLE=0xFFFF, MODE=0xFFFF, pulse IrqIn[5] one cycle -> EIC_IntReq=1 with EIC_IntId=5 two cycles after the pulse; on Ack, STATUS=0x8000_0205 and PENDING=0.
REQ-033 Scenario: IrqIn[3] and IrqIn[9] edges together, PRIO=0x0200 -> EIC_IntId=9 first; after Ack and EOI -> EIC_IntId=3.
REQ-034 Scenario: level channel 2 high, then retracted in REQ before Ack -> EIC_IntReq stays 1 with EIC_IntId=2 until Ack; after EOI no new request.
REQ-035 Scenario: W1C of PENDING bit 4 in the same cycle as a new edge on IrqIn[4] -> PENDING reads 0x10.
REQ-036 Scenario: Sys_Reset=0 asserted mid-REQ -> EIC_IntReq=0 without waiting for a clock; all registers read 0 after release.
REQ-037 Scenario: NUM_IRQ=32, edge on IrqIn[31] -> EIC_IntId=31 and reading unmapped address 7 returns 0.
